fifo_wr_arbiter: RTL and testbench

- Write-side scheduler for the asynchronous FIFO. Lives entirely in the write clock domain.
- Shares the FIFO's single write port (w_en, data_in, full) among NUM_REQ requesters.
- Arbitration is round-robin. Each grant is held for a burst that ends on the requester's "last" flag or at MAX_BURST beats.
- Keeps packets contiguous in the FIFO and bounds how long any one requester can hold the port.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO-side schedulers.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // A one-requester configuration still needs a 1-bit index.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    // Wrap is an explicit subtract so non-power-of-two NUM_REQ works.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing the async FIFO's single write port.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [ID_WIDTH-1:0]           gnt_id,
    output logic                          busy
);

    localparam int CNT_WIDTH = burst_cnt_width(MAX_BURST);
    localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_BURST - 1);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  granted;
    logic                  burst_end;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Write port is driven straight from the held grant, so a beat costs no extra cycle.
    always_comb begin
        granted   = (state_q == GRANT);
        busy      = granted;
        gnt_id    = gnt_id_q;
        w_en      = granted && req_valid[gnt_id_q] && !full;
        req_ready = '0;
        if (granted && !full) begin
            req_ready[gnt_id_q] = 1'b1;
        end
        data_in   = granted ? req_data[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
        burst_end = w_en && (req_last[gnt_id_q] || (burst_cnt_q == CNT_LAST));
    end

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_id_d = pick_idx;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    rr_ptr_d    = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_WIDTH'(1);
                    burst_cnt_d = '0;
                    state_d     = IDLE;
                end else if (w_en) begin
                    burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with per-requester source queues and a write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic            wclk = 1'b0;
    logic            wrst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            full;
    logic            w_en;
    logic [DW-1:0]   data_in;
    logic [1:0]      gnt_id;
    logic            busy;

    logic [8:0]      src_q [NREQ][$];
    logic [9:0]      sb_q [$];
    logic [NREQ-1:0] accept_flag = '0;
    logic [NREQ-1:0] hold = '0;
    int              checks = 0;
    int              failures = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .w_en      (w_en),
        .data_in   (data_in),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requesters present the head of their queue and retire it after an accepted beat.
    always @(negedge wclk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept_flag[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
            if (src_q[i].size() > 0) begin
                req_valid[i]          = !hold[i];
                req_last[i]           = src_q[i][0][8];
                req_data[i*DW +: DW]  = src_q[i][0][7:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    end

    // Every FIFO write must match the next scoreboard entry {requester, data}.
    always begin
        @(negedge wclk);
        #3;
        for (int i = 0; i < NREQ; i++) begin
            accept_flag[i] = req_ready[i] & req_valid[i];
        end
        if (wrst_n && w_en) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_write", {22'd0, gnt_id, data_in}, 32'h3ff);
            end else begin
                check_output("write_word", {22'd0, gnt_id, data_in}, {22'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(negedge wclk);
        #2;
    endtask

    task automatic apply_stimulus(input int id, input logic [7:0] data, input logic last);
        src_q[id].push_back({last, data});
        sb_q.push_back({2'(id), data});
    endtask

    task automatic check_beat(input string tag, input logic [1:0] id);
        check_output({tag, "_gnt"}, 32'(gnt_id), 32'(id));
        check_output({tag, "_wen"}, 32'(w_en), 32'd1);
        check_output({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_wen"}, 32'(w_en), 32'd0);
        check_output({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 80 && sb_q.size() != 0; n++) begin
            step();
        end
        step();
        step();
        check_output({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge wclk);
        #1;
        wrst_n = 1'b0;
        full   = 1'b0;
        hold   = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
        end
        sb_q.delete();
        step();
        step();
        wrst_n = 1'b1;
    endtask

    initial begin
        wrst_n = 1'b0;
        full   = 1'b0;
        step();
        check_idle("reset");
        check_output("reset_gnt", 32'(gnt_id), 32'd0);
        check_output("reset_data", 32'(data_in), 32'd0);
        check_output("reset_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        wrst_n = 1'b1;

        // Single requester, three-word packet.
        step();
        apply_stimulus(2, 8'hA1, 1'b0);
        apply_stimulus(2, 8'hA2, 1'b0);
        apply_stimulus(2, 8'hA3, 1'b1);
        step();
        check_idle("t1_first_idle");
        step();
        check_beat("t1_b0", 2'd2);
        check_output("t1_busy", 32'(busy), 32'd1);
        check_output("t1_data", 32'(data_in), 32'hA1);
        step();
        check_beat("t1_b1", 2'd2);
        step();
        check_beat("t1_b2", 2'd2);
        step();
        check_idle("t1_done");
        check_output("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
        drain("t1");

        // Fairness: all four continuously valid with one-word packets.
        reset_dut();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                apply_stimulus(i, 8'(64 + i*4 + j), 1'b1);
            end
        end
        step();
        for (int j = 0; j < 6; j++) begin
            step();
            check_beat("t2_grant", 2'(j % 4));
            step();
            check_idle("t2_bubble");
        end
        drain("t2");

        // Burst cap: six words, last only on the sixth.
        step();
        for (int j = 0; j < 6; j++) begin
            apply_stimulus(1, 8'(8'hB0 + j), (j == 5));
        end
        step();
        for (int j = 0; j < 4; j++) begin
            step();
            check_beat("t3_burst", 2'd1);
            check_output("t3_cnt", 32'(dut.burst_cnt_q), 32'(j));
        end
        step();
        check_idle("t3_cap_bubble");
        step();
        check_beat("t3_rest0", 2'd1);
        step();
        check_beat("t3_rest1", 2'd1);
        step();
        check_idle("t3_done");
        drain("t3");

        // Full backpressure in the middle of a burst.
        step();
        for (int j = 0; j < 4; j++) begin
            apply_stimulus(0, 8'(8'hC0 + j), (j == 3));
        end
        step();
        step();
        check_beat("t4_b0", 2'd0);
        @(negedge wclk);
        #1;
        full = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            check_output("t4_full_wen", 32'(w_en), 32'd0);
            check_output("t4_full_ready", 32'(req_ready), 32'd0);
            check_output("t4_full_busy", 32'(busy), 32'd1);
            check_output("t4_full_cnt", 32'(dut.burst_cnt_q), 32'd1);
        end
        @(negedge wclk);
        #1;
        full = 1'b0;
        #1;
        check_beat("t4_b1", 2'd0);
        check_output("t4_b1_data", 32'(data_in), 32'hC1);
        step();
        check_output("t4_b2_cnt", 32'(dut.burst_cnt_q), 32'd2);
        step();
        check_beat("t4_b3", 2'd0);
        step();
        check_idle("t4_done");
        drain("t4");

        // Valid gap on the grant holder while another requester waits.
        step();
        apply_stimulus(3, 8'hD1, 1'b0);
        apply_stimulus(3, 8'hD2, 1'b1);
        apply_stimulus(0, 8'hE1, 1'b1);
        step();
        step();
        check_beat("t5_first", 2'd3);
        hold[3] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            check_output("t5_gap_gnt", 32'(gnt_id), 32'd3);
            check_output("t5_gap_wen", 32'(w_en), 32'd0);
            check_output("t5_gap_ready", 32'(req_ready), 32'h8);
        end
        hold[3] = 1'b0;
        step();
        check_beat("t5_last", 2'd3);
        step();
        check_idle("t5_bubble");
        step();
        check_beat("t5_req0", 2'd0);
        drain("t5");

        // Asynchronous reset during the second word of a burst.
        step();
        apply_stimulus(2, 8'hF1, 1'b0);
        apply_stimulus(2, 8'hF2, 1'b0);
        apply_stimulus(2, 8'hF3, 1'b1);
        step();
        step();
        check_beat("t6_b0", 2'd2);
        @(negedge wclk);
        #1;
        wrst_n = 1'b0;
        #1;
        check_idle("t6_reset");
        check_output("t6_reset_gnt", 32'(gnt_id), 32'd0);
        check_output("t6_reset_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        src_q[2].delete();
        sb_q.delete();
        step();
        step();
        wrst_n = 1'b1;
        apply_stimulus(1, 8'h11, 1'b1);
        apply_stimulus(2, 8'h22, 1'b1);
        step();
        check_idle("t6_post_idle");
        step();
        check_beat("t6_regrant", 2'd1);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
